mc_ctrl_fsm: RTL and testbench

//  Multicycle control FSM for the 16-bit, 4-register MIPS-subset datapath. Replaces the combinational main control.

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_ctrl_fsm_alu_decode.sv | 21 ++
 rtl/mc_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle control FSM
// State, opcode, ALU and mux-select codes plus the registered control bundle.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_MEMADR = 4'd3,
      ST_MEMRD  = 4'd4,
      ST_MEMWB  = 4'd5,
      ST_MEMWR  = 4'd6,
      ST_EXEC   = 4'd7,
      ST_RWB    = 4'd8,
      ST_BRANCH = 4'd9,
      ST_JUMP   = 4'd10,
      ST_HALT   = 4'd11
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_ADDI = 4'b0100;
   localparam logic [3:0] OP_LW   = 4'b0101;
   localparam logic [3:0] OP_SW   = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_J    = 4'b1001;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       pc_write;
      logic       pc_write_cond;
      logic       halted;
   } ctrl_t;

   function automatic logic is_rtype(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_decode.sv
// rtl/mc_ctrl_fsm_alu_decode.sv - opcode to ALU operation for R-type and ADDI
// Anything that is not a logic/compare op adds, which covers ADD and ADDI.
module mc_alu_decode
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] op,
   output logic [2:0] alu_op
);

   always_comb begin
      alu_op = ALU_ADD;
      case (op)
         OP_SUB:  alu_op = ALU_SUB;
         OP_AND:  alu_op = ALU_AND;
         OP_OR:   alu_op = ALU_OR;
         OP_SLT:  alu_op = ALU_SLT;
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS-subset control FSM with memory wait timeout
// Optional J instruction enabled by defining MC_CTRL_JUMP_EN.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 8,
   parameter int WAIT_W       = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       run,
   input  logic [3:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_source,
   output logic       halted,
   output logic       err
);

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                err_q, err_d;
   ctrl_t               ctrl_q, ctrl_d;
   logic                mem_wait;
   logic [2:0]          dec_alu_op;

   mc_alu_decode u_alu_decode (
      .op     (op),
      .alu_op (dec_alu_op)
   );

   always_comb begin
      state_d  = state_q;
      wait_d   = '0;
      err_d    = err_q;
      mem_wait = 1'b0;
      case (state_q)
         ST_IDLE:   if (run) state_d = ST_FETCH;
         ST_FETCH:  if (mem_ready) state_d = ST_DECODE; else mem_wait = 1'b1;
         ST_DECODE: begin
            if (is_rtype(op) || op == OP_ADDI) state_d = ST_EXEC;
            else if (op == OP_LW || op == OP_SW) state_d = ST_MEMADR;
            else if (op == OP_BEQ) state_d = ST_BRANCH;
`ifdef MC_CTRL_JUMP_EN
            else if (op == OP_J) state_d = ST_JUMP;
`endif
            else state_d = ST_HALT;
         end
         ST_EXEC:   state_d = ST_RWB;
         ST_MEMADR: state_d = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB; else mem_wait = 1'b1;
         ST_MEMWR: begin
            if (mem_ready) state_d = run ? ST_FETCH : ST_IDLE;
            else mem_wait = 1'b1;
         end
         ST_RWB, ST_MEMWB, ST_BRANCH, ST_JUMP: state_d = run ? ST_FETCH : ST_IDLE;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_HALT;
      endcase

      // The last tolerated wait cycle is the MEM_WAIT_MAX-th; the request drops on entry to HALT.
      if (mem_wait) begin
         if (MEM_WAIT_MAX != 0 && wait_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
         end else begin
            wait_d = wait_q + WAIT_W'(1);
         end
      end
   end

   always_comb begin
      ctrl_d = '0;
      case (state_d)
         ST_FETCH: begin
            ctrl_d.mem_read  = 1'b1;
            ctrl_d.alu_src_b = SRCB_FOUR;
            ctrl_d.alu_op    = ALU_ADD;
         end
         ST_DECODE: begin
            ctrl_d.alu_src_b = SRCB_IMM_SH2;
            ctrl_d.alu_op    = ALU_ADD;
         end
         ST_EXEC: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = is_rtype(op) ? SRCB_REG : SRCB_IMM;
            ctrl_d.alu_op    = dec_alu_op;
         end
         ST_RWB: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.reg_dst   = is_rtype(op);
         end
         ST_MEMADR: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = SRCB_IMM;
            ctrl_d.alu_op    = ALU_ADD;
         end
         ST_MEMRD: begin
            ctrl_d.mem_read = 1'b1;
            ctrl_d.i_or_d   = 1'b1;
         end
         ST_MEMWB: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
         end
         ST_MEMWR: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.i_or_d    = 1'b1;
         end
         ST_BRANCH: begin
            ctrl_d.alu_src_a     = 1'b1;
            ctrl_d.alu_src_b     = SRCB_REG;
            ctrl_d.alu_op        = ALU_SUB;
            ctrl_d.pc_write_cond = 1'b1;
            ctrl_d.pc_source     = PCSRC_ALUOUT;
         end
`ifdef MC_CTRL_JUMP_EN
         ST_JUMP: begin
            ctrl_d.pc_write  = 1'b1;
            ctrl_d.pc_source = PCSRC_JUMP;
         end
`endif
         ST_HALT:  ctrl_d.halted = 1'b1;
         default:  ctrl_d = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         wait_q  <= '0;
         err_q   <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Fetch completion strobes follow mem_ready in the same cycle; everything else is registered.
   assign ir_write   = (state_q == ST_FETCH) && mem_ready;
   assign pc_en      = ir_write || ctrl_q.pc_write || (ctrl_q.pc_write_cond && zero);
   assign i_or_d     = ctrl_q.i_or_d;
   assign mem_read   = ctrl_q.mem_read;
   assign mem_write  = ctrl_q.mem_write;
   assign reg_dst    = ctrl_q.reg_dst;
   assign mem_to_reg = ctrl_q.mem_to_reg;
   assign reg_write  = ctrl_q.reg_write;
   assign alu_src_a  = ctrl_q.alu_src_a;
   assign alu_src_b  = ctrl_q.alu_src_b;
   assign alu_op     = ctrl_q.alu_op;
   assign pc_source  = ctrl_q.pc_source;
   assign halted     = ctrl_q.halted;
   assign err        = err_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed and randomized instruction sequences for mc_ctrl_fsm
// Expected outputs are built per instruction from its cycle-by-cycle phase list.
module tb_mc_ctrl_fsm;

   logic       clock = 1'b0;
   logic       reset_n, run, zero, mem_ready;
   logic [3:0] op;
   logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
   logic       reg_write, alu_src_a, halted, err;
   logic [1:0] alu_src_b, pc_source;
   logic [2:0] alu_op;
   logic [17:0] obs;
   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   mc_ctrl_fsm #(.MEM_WAIT_MAX(8), .WAIT_W(4)) dut (
      .clock(clock), .reset_n(reset_n), .run(run), .op(op), .zero(zero),
      .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
      .halted(halted), .err(err)
   );

   assign obs = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted, err};

   function automatic logic [17:0] mk(input logic pe, iod, mr, mw, irw, rd, m2r, rw, sa,
                                      input logic [1:0] sb, input logic [2:0] ao,
                                      input logic [1:0] ps, input logic h, e);
      return {pe, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, h, e};
   endfunction

   function automatic logic [2:0] exp_alu(input logic [3:0] o);
      case (o)
         4'b0001: return 3'b110;
         4'b0010: return 3'b000;
         4'b0011: return 3'b001;
         4'b0111: return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   function automatic logic [17:0] v_fetch(input logic r);
      return mk(r,0,1,0,r,0,0,0,0,2'b01,3'b010,2'b00,0,0);
   endfunction
   function automatic logic [17:0] v_decode();
      return mk(0,0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
   endfunction
   function automatic logic [17:0] v_exec(input logic [3:0] o);
      return mk(0,0,0,0,0,0,0,0,1,(o == 4'b0100) ? 2'b10 : 2'b00,exp_alu(o),2'b00,0,0);
   endfunction
   function automatic logic [17:0] v_rwb(input logic [3:0] o);
      return mk(0,0,0,0,0,(o != 4'b0100),0,1,0,2'b00,3'b000,2'b00,0,0);
   endfunction
   function automatic logic [17:0] v_memadr();
      return mk(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
   endfunction
   function automatic logic [17:0] v_memrd();
      return mk(0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0);
   endfunction
   function automatic logic [17:0] v_memwb();
      return mk(0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,0);
   endfunction
   function automatic logic [17:0] v_memwr();
      return mk(0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0);
   endfunction
   function automatic logic [17:0] v_branch(input logic z);
      return mk(z,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,0);
   endfunction
   function automatic logic [17:0] v_jump();
      return mk(1,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0,0);
   endfunction
   function automatic logic [17:0] v_halt(input logic e);
      return mk(0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,e);
   endfunction

   // Called at a negedge: apply inputs, check outputs, advance to the next negedge.
   task automatic cyc(input logic rdy, input logic z, input logic [17:0] e, input string tag);
      mem_ready = rdy;
      zero      = z;
      #1;
      vectors++;
      assert (obs === e) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, e);
      end
      @(negedge clock);
   endtask

   function automatic logic rb();
      return 1'($urandom % 2);
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      run     = 1'b0;
      @(negedge clock);
      cyc(rb(), rb(), 18'd0, "reset");
      reset_n = 1'b1;
      run     = 1'b1;
      cyc(rb(), rb(), 18'd0, "idle_start");
   endtask

   task automatic run_instr(input logic [3:0] o, input int wf, input int wm,
                            input logic z, input logic ra);
      op = o;
      for (int i = 0; i < wf; i++) cyc(1'b0, rb(), v_fetch(1'b0), "fetch_wait");
      cyc(1'b1, rb(), v_fetch(1'b1), "fetch_done");
      cyc(rb(), rb(), v_decode(), "decode");
      case (o)
         4'b0101: begin
            cyc(rb(), rb(), v_memadr(), "lw_memadr");
            for (int i = 0; i < wm; i++) cyc(1'b0, rb(), v_memrd(), "memrd_wait");
            cyc(1'b1, rb(), v_memrd(), "memrd_done");
            run = ra;
            cyc(rb(), rb(), v_memwb(), "memwb");
         end
         4'b0110: begin
            cyc(rb(), rb(), v_memadr(), "sw_memadr");
            for (int i = 0; i < wm; i++) cyc(1'b0, rb(), v_memwr(), "memwr_wait");
            run = ra;
            cyc(1'b1, rb(), v_memwr(), "memwr_done");
         end
         4'b1000: begin
            run = ra;
            cyc(rb(), z, v_branch(z), "branch");
         end
         4'b1001: begin
            run = ra;
            cyc(rb(), rb(), v_jump(), "jump");
         end
         default: begin
            cyc(rb(), rb(), v_exec(o), "exec");
            run = ra;
            cyc(rb(), rb(), v_rwb(o), "rwb");
         end
      endcase
      if (!ra) begin
         cyc(rb(), rb(), 18'd0, "idle_after");
         run = 1'b1;
         cyc(rb(), rb(), 18'd0, "idle_restart");
      end
   endtask

   task automatic run_halt(input logic [3:0] o, input string tag);
      op = o;
      cyc(1'b1, rb(), v_fetch(1'b1), "fetch_done");
      cyc(rb(), rb(), v_decode(), "decode");
      cyc(rb(), rb(), v_halt(1'b0), tag);
      cyc(rb(), rb(), v_halt(1'b0), tag);
      do_reset();
   endtask

   logic [3:0] legal_ops [$];

   initial begin
      reset_n = 1'b0; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; op = 4'b0000;
      do_reset();

      run_instr(4'b0000, 0, 0, 1'b0, 1'b1);
      run_instr(4'b0101, 0, 3, 1'b0, 1'b1);
      run_instr(4'b1000, 0, 0, 1'b1, 1'b1);
      run_instr(4'b1000, 0, 0, 1'b0, 1'b1);
      run_instr(4'b0110, 2, 1, 1'b0, 1'b0);
      run_instr(4'b0100, 1, 0, 1'b0, 1'b1);
      run_instr(4'b0111, 0, 0, 1'b0, 1'b1);
      run_instr(4'b0101, 7, 7, 1'b0, 1'b1);

`ifdef MC_CTRL_JUMP_EN
      run_instr(4'b1001, 0, 0, 1'b0, 1'b1);
      do_reset();
`else
      run_halt(4'b1001, "j_illegal_halt");
`endif
      run_halt(4'b1010, "illegal_halt");
      run_halt(4'b1111, "illegal_halt_f");

      op = 4'b0000;
      for (int i = 0; i < 8; i++) cyc(1'b0, rb(), v_fetch(1'b0), "timeout_wait");
      cyc(1'b0, rb(), v_halt(1'b1), "timeout_halt");
      cyc(1'b1, rb(), v_halt(1'b1), "timeout_stay");
      do_reset();

      op = 4'b0101;
      cyc(1'b1, rb(), v_fetch(1'b1), "fetch_done");
      cyc(rb(), rb(), v_decode(), "decode");
      cyc(rb(), rb(), v_memadr(), "lw_memadr");
      cyc(1'b0, rb(), v_memrd(), "memrd_wait");
      reset_n = 1'b0;
      cyc(1'b0, rb(), v_memrd(), "memrd_pre_reset");
      reset_n = 1'b1;
      run = 1'b0;
      cyc(rb(), rb(), 18'd0, "rst_mid_memrd");
      run = 1'b1;
      cyc(rb(), rb(), 18'd0, "idle_restart");

      legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111,
                    4'b0100, 4'b0101, 4'b0110, 4'b1000};
`ifdef MC_CTRL_JUMP_EN
      legal_ops.push_back(4'b1001);
`endif
      for (int n = 0; n < 200; n++) begin
         int wf, wm;
         wf = ($urandom % 4 == 0) ? int'($urandom_range(0, 7)) : 0;
         wm = ($urandom % 3 == 0) ? int'($urandom_range(0, 7)) : 0;
         run_instr(legal_ops[$urandom_range(0, legal_ops.size() - 1)], wf, wm,
                   rb(), ($urandom % 5) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
